// File: rtl/sys_defs.sv
// Shared definitions for the execute stage: data width, multiplier depth,
// channel / ALU function / operand-select encodings and the issue/execute packets.
// Latency: n/a (types only). Backpressure: n/a.
package sys_defs;

   localparam int XLEN        = 32;
   localparam int MULT_STAGES = 4;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [1:0] {
      CH_ALU  = 2'd0,
      CH_BR   = 2'd1,
      CH_MULT = 2'd2,
      CH_NONE = 2'd3
   } CHANNEL;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'h00,
      ALU_SUB    = 5'h01,
      ALU_SLT    = 5'h02,
      ALU_SLTU   = 5'h03,
      ALU_AND    = 5'h04,
      ALU_OR     = 5'h05,
      ALU_XOR    = 5'h06,
      ALU_SLL    = 5'h07,
      ALU_SRL    = 5'h08,
      ALU_SRA    = 5'h09,
      ALU_MUL    = 5'h0a,
      ALU_MULH   = 5'h0b,
      ALU_MULHSU = 5'h0c,
      ALU_MULHU  = 5'h0d,
      ALU_DIV    = 5'h0e,
      ALU_DIVU   = 5'h0f,
      ALU_REM    = 5'h10,
      ALU_REMU   = 5'h11
   } ALU_FUNC;

   typedef enum logic [1:0] {
      OPA_IS_RS1  = 2'd0,
      OPA_IS_NPC  = 2'd1,
      OPA_IS_PC   = 2'd2,
      OPA_IS_ZERO = 2'd3
   } ALU_OPA_SELECT;

   typedef enum logic [2:0] {
      OPB_IS_RS2   = 3'd0,
      OPB_IS_I_IMM = 3'd1,
      OPB_IS_S_IMM = 3'd2,
      OPB_IS_B_IMM = 3'd3,
      OPB_IS_U_IMM = 3'd4,
      OPB_IS_J_IMM = 3'd5
   } ALU_OPB_SELECT;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] rs1_value;
      logic [XLEN-1:0] rs2_value;
      ALU_OPA_SELECT   opa_select;
      ALU_OPB_SELECT   opb_select;
      ALU_FUNC         alu_func;
      CHANNEL          channel;
      logic [4:0]      dest_reg_idx;
      logic [5:0]      rob_tag;
   } IS_PACKET;

   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic            take_branch;
      logic [XLEN-1:0] PC;
      logic [4:0]      dest_reg_idx;
      logic [5:0]      rob_tag;
   } EX_PACKET;

endpackage

// File: rtl/ex_mult.sv
// Pipelined multiplier: MUL/MULH/MULHSU/MULHU with a valid/packet shift chain.
// Latency: STAGES edges from issue to out_vld; one new multiply accepted per cycle.
// Backpressure: none; the result is always emitted and wins output arbitration upstream.
// Ports: clock/reset (sync, active-high); in_vld/in_a/in_b/in_func/in_pkt issue side;
//        out_vld/out_pkt completion side (pass-through fields travel with the product).
module ex_mult
   import sys_defs::*;
#(
   parameter int STAGES = MULT_STAGES
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_vld,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  ALU_FUNC         in_func,
   input  EX_PACKET        in_pkt,
   output logic            out_vld,
   output EX_PACKET        out_pkt
);

   logic              a_sgn, b_sgn;
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   EX_PACKET          head;

   logic [STAGES-1:0] vld_d, vld_q;
   EX_PACKET          pkt_d [STAGES];
   EX_PACKET          pkt_q [STAGES];

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (in_func)
         ALU_MULH: begin
            a_sgn = in_a[XLEN-1];
            b_sgn = in_b[XLEN-1];
         end
         ALU_MULHSU: a_sgn = in_a[XLEN-1];
         default: ;
      endcase
      // Extending to 2*XLEN makes an unsigned multiply produce the correct
      // signed/unsigned product modulo 2^(2*XLEN) for every variant.
      a_ext = {{XLEN{a_sgn}}, in_a};
      b_ext = {{XLEN{b_sgn}}, in_b};
      prod  = a_ext * b_ext;

      head             = in_pkt;
      head.take_branch = 1'b0;
      head.alu_result  = (in_func == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

      vld_d    = {vld_q[STAGES-2:0], in_vld};
      pkt_d[0] = head;
      for (int i = 1; i < STAGES; i++) begin
         pkt_d[i] = pkt_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pkt_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         pkt_q <= pkt_d;
      end
   end

   assign out_vld = vld_q[STAGES-1];
   assign out_pkt = pkt_q[STAGES-1];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxes, ALU and branch unit inline, pipelined multiplier in ex_mult.
// Latency: ALU/BR same cycle (combinational); MULT MULT_STAGES edges after issue.
// Backpressure: a completing multiply owns the output; a same-cycle ALU/BR input raises no_output for replay.
// Ports: clock, reset (sync, active-high), is_packet_in, ex_packet_out, valid, no_output.
// Optional: define EX_TRACE_EN to print one trace line per valid output at each rising edge.
module ex_stage
   import sys_defs::*;
(
   input  logic     clock,
   input  logic     reset,
   input  IS_PACKET is_packet_in,
   output EX_PACKET ex_packet_out,
   output logic     valid,
   output logic     no_output
);

   logic [31:0]     inst;
   logic [XLEN-1:0] rs1, rs2, pc;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] opa, opb, alu_res, br_target;
   logic            br_take, ab_vld, mult_in_vld, mult_vld;
   EX_PACKET        pass_pkt, mult_pkt;

   assign inst = is_packet_in.inst;
   assign rs1  = is_packet_in.rs1_value;
   assign rs2  = is_packet_in.rs2_value;
   assign pc   = is_packet_in.PC;

   assign ab_vld      = (is_packet_in.channel == CH_ALU) || (is_packet_in.channel == CH_BR);
   assign mult_in_vld = (is_packet_in.channel == CH_MULT);

   always_comb begin
      imm_i = {{20{inst[31]}}, inst[31:20]};
      imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      imm_u = {inst[31:12], 12'b0};
      imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

      case (is_packet_in.opa_select)
         OPA_IS_RS1: opa = rs1;
         OPA_IS_NPC: opa = pc + 32'd4;
         OPA_IS_PC:  opa = pc;
         default:    opa = '0;
      endcase

      case (is_packet_in.opb_select)
         OPB_IS_I_IMM: opb = imm_i;
         OPB_IS_S_IMM: opb = imm_s;
         OPB_IS_B_IMM: opb = imm_b;
         OPB_IS_U_IMM: opb = imm_u;
         OPB_IS_J_IMM: opb = imm_j;
         default:      opb = rs2;
      endcase

      case (is_packet_in.alu_func)
         ALU_ADD:  alu_res = opa + opb;
         ALU_SUB:  alu_res = opa - opb;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
         ALU_AND:  alu_res = opa & opb;
         ALU_OR:   alu_res = opa | opb;
         ALU_XOR:  alu_res = opa ^ opb;
         ALU_SLL:  alu_res = opa << opb[4:0];
         ALU_SRL:  alu_res = opa >> opb[4:0];
         ALU_SRA:  alu_res = $unsigned($signed(opa) >>> opb[4:0]);
         default:  alu_res = '0;
      endcase

      br_target = opa + opb;

      // Condition uses the raw register values, never the muxed operands.
      case (inst[14:12])
         3'b000:  br_take = (rs1 == rs2);
         3'b001:  br_take = (rs1 != rs2);
         3'b100:  br_take = ($signed(rs1) <  $signed(rs2));
         3'b101:  br_take = ($signed(rs1) >= $signed(rs2));
         3'b110:  br_take = (rs1 <  rs2);
         3'b111:  br_take = (rs1 >= rs2);
         default: br_take = 1'b0;
      endcase
      if ((inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR)) begin
         br_take = 1'b1;
      end
   end

   always_comb begin
      pass_pkt              = '0;
      pass_pkt.PC           = pc;
      pass_pkt.dest_reg_idx = is_packet_in.dest_reg_idx;
      pass_pkt.rob_tag      = is_packet_in.rob_tag;
   end

   ex_mult #(.STAGES(MULT_STAGES)) u_mult (
      .clock   (clock),
      .reset   (reset),
      .in_vld  (mult_in_vld),
      .in_a    (opa),
      .in_b    (opb),
      .in_func (is_packet_in.alu_func),
      .in_pkt  (pass_pkt),
      .out_vld (mult_vld),
      .out_pkt (mult_pkt)
   );

   always_comb begin
      ex_packet_out = '0;
      valid         = 1'b0;
      no_output     = 1'b0;
      if (!reset) begin
         if (mult_vld) begin
            ex_packet_out = mult_pkt;
            valid         = 1'b1;
            no_output     = ab_vld;
         end else if (ab_vld) begin
            ex_packet_out = pass_pkt;
            if (is_packet_in.channel == CH_BR) begin
               ex_packet_out.alu_result  = br_target;
               ex_packet_out.take_branch = br_take;
            end else begin
               ex_packet_out.alu_result  = alu_res;
            end
            valid = 1'b1;
         end
      end
   end

`ifdef EX_TRACE_EN
   always_ff @(posedge clock) begin
      if (valid) begin
         $display("[EX] t=%0t PC=%08h ch=%0d res=%08h br=%0b no_out=%0b",
                  $time, ex_packet_out.PC, mult_vld ? CH_MULT : is_packet_in.channel,
                  ex_packet_out.alu_result, ex_packet_out.take_branch, no_output);
      end
   end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: one vector per cycle; multiply results are queued with their
// due cycle and compared when the DUT should complete them.
module tb_ex_stage;
   import sys_defs::*;

   logic     clock = 1'b0;
   logic     reset;
   IS_PACKET is_packet_in;
   EX_PACKET ex_packet_out;
   logic     valid, no_output;

   ex_stage dut (
      .clock         (clock),
      .reset         (reset),
      .is_packet_in  (is_packet_in),
      .ex_packet_out (ex_packet_out),
      .valid         (valid),
      .no_output     (no_output)
   );

   always #5 clock = ~clock;

   typedef struct {
      IS_PACKET    pkt;
      logic [31:0] exp_res;
      logic        exp_take;
      logic        rst;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] res;
      logic [5:0]  tag;
   } sb_t;

   localparam logic [31:0] A = 32'h87654321;
   localparam logic [31:0] B = 32'h12345678;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   vec_t vecs[$];
   sb_t  sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic IS_PACKET mk(CHANNEL ch, ALU_FUNC f, ALU_OPA_SELECT sa, ALU_OPB_SELECT sbs,
                                   logic [31:0] inst, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2);
      IS_PACKET p;
      p            = '0;
      p.channel    = ch;
      p.alu_func   = f;
      p.opa_select = sa;
      p.opb_select = sbs;
      p.inst       = inst;
      p.PC         = pc;
      p.rs1_value  = r1;
      p.rs2_value  = r2;
      return p;
   endfunction

   function automatic IS_PACKET alu(ALU_FUNC f, logic [31:0] r1, logic [31:0] r2);
      return mk(CH_ALU, f, OPA_IS_RS1, OPB_IS_RS2, 32'h0, 32'h0, r1, r2);
   endfunction

   function automatic IS_PACKET mul(ALU_FUNC f, logic [31:0] r1, logic [31:0] r2);
      return mk(CH_MULT, f, OPA_IS_RS1, OPB_IS_RS2, 32'h0, 32'h0, r1, r2);
   endfunction

   // PC=15, inst[11:8]=0010 gives B-imm 4, so the target is always 19.
   function automatic IS_PACKET br(logic [2:0] f3, logic [6:0] opc, logic [31:0] r1, logic [31:0] r2);
      return mk(CH_BR, ALU_ADD, OPA_IS_PC, OPB_IS_B_IMM, {17'b0, f3, 4'b0010, 1'b0, opc}, 32'd15, r1, r2);
   endfunction

   function automatic IS_PACKET bubble();
      return mk(CH_NONE, ALU_ADD, OPA_IS_RS1, OPB_IS_RS2, 32'h0, 32'h0, A, B);
   endfunction

   task automatic add(IS_PACKET p, logic [31:0] r, logic t, logic rst);
      vec_t v;
      v.pkt = p; v.exp_res = r; v.exp_take = t; v.rst = rst;
      vecs.push_back(v);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   initial begin
      // reset state, including a multiply issued while reset is high
      add(alu(ALU_ADD, A, B), 32'h0, 1'b0, 1'b1);
      add(mul(ALU_MUL, 32'd5, 32'd5), 32'd25, 1'b0, 1'b1);
      // ALU functions
      add(alu(ALU_ADD,  A, B), 32'h99999999, 1'b0, 1'b0);
      add(alu(ALU_SUB,  A, B), 32'h7530ECA9, 1'b0, 1'b0);
      add(alu(ALU_AND,  A, B), 32'h02244220, 1'b0, 1'b0);
      add(alu(ALU_OR,   A, B), 32'h97755779, 1'b0, 1'b0);
      add(alu(ALU_XOR,  A, B), 32'h95511559, 1'b0, 1'b0);
      add(alu(ALU_SLT,  A, B), 32'h00000001, 1'b0, 1'b0);
      add(alu(ALU_SLTU, A, B), 32'h00000000, 1'b0, 1'b0);
      add(alu(ALU_SLL,  A, B), 32'h21000000, 1'b0, 1'b0);
      add(alu(ALU_SRL,  A, B), 32'h00000087, 1'b0, 1'b0);
      add(alu(ALU_SRA,  A, B), 32'hFFFFFF87, 1'b0, 1'b0);
      add(alu(ALU_DIV,  A, B), 32'h00000000, 1'b0, 1'b0);
      add(bubble(), 32'h0, 1'b0, 1'b0);
      // operand muxes and immediates
      add(mk(CH_ALU, ALU_ADD, OPA_IS_NPC,  OPB_IS_I_IMM, 32'hFFF00013, 32'h100, A, B), 32'h00000103, 1'b0, 1'b0);
      add(mk(CH_ALU, ALU_ADD, OPA_IS_ZERO, OPB_IS_U_IMM, 32'h12345037, 32'h100, A, B), 32'h12345000, 1'b0, 1'b0);
      add(mk(CH_ALU, ALU_ADD, OPA_IS_RS1,  OPB_IS_S_IMM, 32'hFE000FA3, 32'h100, 32'h10, B), 32'h0000000F, 1'b0, 1'b0);
      // branches
      add(br(3'b000, OP_BRANCH, A, A), 32'd19, 1'b1, 1'b0);
      add(br(3'b000, OP_BRANCH, A, B), 32'd19, 1'b0, 1'b0);
      add(br(3'b001, OP_BRANCH, A, B), 32'd19, 1'b1, 1'b0);
      add(br(3'b100, OP_BRANCH, A, B), 32'd19, 1'b1, 1'b0);
      add(br(3'b101, OP_BRANCH, A, B), 32'd19, 1'b0, 1'b0);
      add(br(3'b110, OP_BRANCH, A, B), 32'd19, 1'b0, 1'b0);
      add(br(3'b111, OP_BRANCH, A, B), 32'd19, 1'b1, 1'b0);
      add(br(3'b010, OP_BRANCH, A, B), 32'd19, 1'b0, 1'b0);
      add(br(3'b010, OP_JAL,    A, B), 32'd19, 1'b1, 1'b0);
      // multiply pipeline collides with ALU traffic
      add(mul(ALU_MUL,  32'd1, 32'd2), 32'h00000002, 1'b0, 1'b0);
      add(mul(ALU_MULH, 32'd3, 32'd3), 32'h00000000, 1'b0, 1'b0);
      add(alu(ALU_SUB, A, B), 32'h7530ECA9, 1'b0, 1'b0);
      add(alu(ALU_AND, A, B), 32'h02244220, 1'b0, 1'b0);
      add(alu(ALU_OR,  A, B), 32'h97755779, 1'b0, 1'b0);
      add(alu(ALU_XOR, A, B), 32'h95511559, 1'b0, 1'b0);
      // signedness variants back to back
      add(mul(ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000000, 1'b0, 1'b0);
      add(mul(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF, 1'b0, 1'b0);
      add(mul(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE, 1'b0, 1'b0);
      add(mul(ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000001, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) add(bubble(), 32'h0, 1'b0, 1'b0);
      // branch input colliding with a completing multiply
      add(mul(ALU_MUL, 32'd7, 32'd6), 32'd42, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) add(bubble(), 32'h0, 1'b0, 1'b0);
      add(br(3'b001, OP_BRANCH, A, B), 32'd19, 1'b1, 1'b0);
      // reset while a multiply is in flight
      add(mul(ALU_MUL, 32'd5, 32'd5), 32'd25, 1'b0, 1'b0);
      add(bubble(), 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) add(bubble(), 32'h0, 1'b0, 1'b0);

      reset        = 1'b1;
      is_packet_in = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t        v;
         logic        ab, ev, eno, etk;
         logic [31:0] er;
         logic [5:0]  etag;
         sb_t         e;
         v = vecs[i];
         v.pkt.rob_tag      = 6'(i);
         v.pkt.dest_reg_idx = 5'(i);
         reset        = v.rst;
         is_packet_in = v.pkt;
         ab   = (v.pkt.channel == CH_ALU) || (v.pkt.channel == CH_BR);
         ev   = 1'b0; eno = 1'b0; etk = 1'b0; er = '0; etag = '0;
         if (v.rst) begin
            sb.delete();
         end else begin
            if (sb.size() > 0 && sb[0].due == i) begin
               e    = sb.pop_front();
               ev   = 1'b1;
               er   = e.res;
               etag = e.tag;
               eno  = ab;
            end else if (ab) begin
               ev   = 1'b1;
               er   = v.exp_res;
               etk  = v.exp_take;
               etag = 6'(i);
            end
            if (v.pkt.channel == CH_MULT) begin
               e.due = i + MULT_STAGES;
               e.res = v.exp_res;
               e.tag = 6'(i);
               sb.push_back(e);
            end
         end
         #4;
         chk($sformatf("v%0d valid", i),       32'(valid), 32'(ev));
         chk($sformatf("v%0d no_output", i),   32'(no_output), 32'(eno));
         chk($sformatf("v%0d alu_result", i),  ex_packet_out.alu_result, er);
         chk($sformatf("v%0d take_branch", i), 32'(ex_packet_out.take_branch), 32'(etk));
         if (ev) chk($sformatf("v%0d rob_tag", i), 32'(ex_packet_out.rob_tag), 32'(etag));
         @(posedge clock);
         #1;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: %0d results still pending, 0 required", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the out-of-order RISC-V core, sitting between issue (IS_PACKET in) and complete (EX_PACKET out).
- Routes each issued instruction by its channel field to one of three units:
  - single-cycle combinational ALU;
  - combinational branch unit;
  - 4-stage pipelined multiplier.
- Merges unit results onto one output, with completing multiplies taking priority.

Parameters:
- MULT_STAGES, 4, number of multiplier pipeline stages. The result appears 4 clock edges after issue.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- is_packet_in  in  IS_PACKET  issued instruction. Fields used: inst, PC, rs1_value, rs2_value, opa_select, opb_select, alu_func, channel, plus pass-through fields.
- ex_packet_out  out  EX_PACKET  result packet: alu_result[XLEN-1:0], take_branch, plus pass-through fields of the producing instruction.
- valid  out  1  ex_packet_out carries a real result this cycle.
- no_output  out  1  this cycle's ALU/BR input was not accepted to the output; issue must replay it.

Behaviour:
- Operand A mux:
  - OPA_IS_RS1 (0) -> rs1_value
  - OPA_IS_NPC -> PC+4
  - OPA_IS_PC -> PC
  - OPA_IS_ZERO -> 0
- Operand B mux:
  - OPB_IS_RS2 (0) -> rs2_value
  - I/S/B/U/J immediates decoded from inst per RV32I and sign-extended.
  - B-imm = {inst[31],inst[7],inst[30:25],inst[11:8],0}, sign-extended.
- ALU (channel ALU), combinational on opA/opB:
  - 0x00 ADD, 0x01 SUB, 0x02 SLT (signed), 0x03 SLTU, 0x04 AND, 0x05 OR, 0x06 XOR.
  - 0x07 SLL, 0x08 SRL, 0x09 SRA; shift amount = opB[4:0].
  - Codes 0x0e–0x11 (DIV/REM family) and any other code -> result 0.
  - All arithmetic is modulo 2^XLEN.
- Branch (channel BR), combinational:
  - alu_result = opA+opB (target address).
  - take_branch compares rs1_value vs rs2_value (never the muxed operands), by func3 = inst[14:12]:
    - 000 BEQ, 001 BNE
    - 100 BLT signed, 101 BGE signed
    - 110 BLTU, 111 BGEU
    - 010/011 -> 0
  - JAL/JALR encodings (opcode) force take_branch=1.
- MULT channel:
  - Functions: 0x0a MUL (low 32 bits), 0x0b MULH (signed×signed, high), 0x0c MULHSU (signed×unsigned, high), 0x0d MULHU (high).
  - Operands are opA/opB. Fully pipelined: one new multiply may issue every cycle.
  - Issued before rising edge k -> result on ex_packet_out combinationally after rising edge k+3, i.e. the 4th edge counting the issue edge.
- Output arbitration, per cycle:
  - A completing multiply owns the output: valid=1, take_branch=0, and its own pass-through fields.
  - If an ALU/BR input is present that same cycle: no_output=1 and the input is dropped (issue replays it).
  - Otherwise an ALU/BR input drives the output: valid=1, no_output=0.
  - A MULT input never produces output in its issue cycle and never sets no_output.
  - Any other channel value: valid=0, no_output=0, alu_result=0, take_branch=0.
- ALU/BR results need no clock edge; they are visible within the same cycle as the input.
- Reset:
  - Clears all multiplier stage valids and data.
  - While reset is high: valid=0, no_output=0, alu_result=0, take_branch=0.
  - A multiply in flight at reset is discarded. The first output after deassert is from new inputs only.
- Back-to-back multiplies complete in issue order on consecutive cycles.

Optional Feature:
- EX_TRACE_EN defined: each rising edge with valid=1, print simulation time, PC, channel, alu_result, take_branch, no_output via $display.
- Not defined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Shared package (sys_defs) holds:
  - XLEN; IS_PACKET and EX_PACKET typedefs.
  - CHANNEL enum (ALU, BR, MULT, others).
  - ALU_FUNC enum with the codes above.
  - ALU_OPA_SELECT and ALU_OPB_SELECT enums.
- One natural sub-module: ex_mult, the 4-stage pipelined multiplier with valid/data/tag shift chain. ALU, branch compare and muxes stay inline.

Test Plan:
- ALU: rs1=0x87654321, rs2=0x12345678, both selects 0 ->
  - ADD 0x99999999, SUB 0x7530ECA9, AND 0x02244220, OR 0x97755779, XOR 0x95511559.
  - valid=1, no_output=0, same cycle.
- Branch: PC=15, inst[11:8]=0010 (B-imm=4), OPA_IS_PC/OPB_IS_B_IMM, alu_result=19 for every case.
  - rs1=rs2=0x87654321: BEQ -> take_branch=1.
  - rs1=0x87654321, rs2=0x12345678: BEQ 0, BNE 1, BLT 1, BGE 0, BLTU 0, BGEU 1.
- Mult pipeline:
  - cycle 0: MUL 1×2; cycle 1: MULH 3×3; cycles 2–5: ALU SUB, AND, OR, XOR on 0x87654321/0x12345678.
  - Outputs: 0x7530ECA9, 0x02244220, then 0x00000002 (mult wins, no_output=1), then 0x00000000 (MULH, no_output=1).
- MULHSU/MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> MULH 0, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE, MUL 0x00000001, each 4 edges after issue.
- Reset mid-flight: issue MUL 5×5, assert reset next cycle -> valid stays 0; no stray 25 ever appears.
- Unused channel/alu_func: DIV code 0x0e on ALU -> alu_result 0; non-ALU/BR/MULT channel -> valid=0.
